// File: rtl/ic_jpeg_pkg.sv
// rtl/ic_jpeg_pkg.sv - shared FSM states and block geometry for the JPEG front end
package ic_jpeg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fetch_state_t;

  localparam int BLK           = 8;
  localparam int BYTES_PER_PIX = 4;

endpackage

// File: rtl/ic_rgb_fetch_fifo.sv
// rtl/ic_rgb_fetch_fifo.sv - show-ahead sync FIFO buffering returned pixels
module ic_rgb_fetch_fifo #(
  parameter int DEPTH = 8,
  parameter int DW    = 24
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    push,
  input  logic                    pop,
  input  logic [DW-1:0]           din,
  output logic [DW-1:0]           dout,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    empty,
  output logic                    full
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  // Storage array; contents need no reset since occupancy is tracked separately
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign dout  = r_mem[r_rd_ptr];
  assign count = r_count;
  assign empty = (r_count == '0);
  assign full  = (r_count == (AW+1)'(DEPTH));

endmodule

// File: rtl/ic_rgb_block_fetch.sv
// rtl/ic_rgb_block_fetch.sv - Avalon-MM reader emitting an RGB raster in 8x8 block order
module ic_rgb_block_fetch
  import ic_jpeg_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DIM_W      = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [DIM_W-1:0]  img_width,
  input  logic [DIM_W-1:0]  img_height,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid,
  output logic              CU_inputready,
  output logic [23:0]       CU_readdata,
  input  logic              R2Y_waitrequest,
  output logic              busy,
  output logic              done
);

  localparam int CW     = $clog2(FIFO_DEPTH) + 1;
  localparam int BW     = DIM_W - 3;
  localparam int PIX_SH = $clog2(BYTES_PER_PIX);
  localparam int BLK_SH = $clog2(BLK);
  localparam logic [ADDR_W-1:0] PIX_STEP = ADDR_W'(BYTES_PER_PIX);
  localparam logic [ADDR_W-1:0] BLK_STEP = ADDR_W'(BLK * BYTES_PER_PIX);
  localparam logic [2:0]        LAST_IDX = 3'(BLK - 1);

  fetch_state_t      r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_row_addr;
  logic [ADDR_W-1:0] r_blk_addr;
  logic [ADDR_W-1:0] r_brow_addr;
  logic [ADDR_W-1:0] r_stride;
  logic [ADDR_W-1:0] r_stride8;
  logic [2:0]        r_c;
  logic [2:0]        r_r;
  logic [BW-1:0]     r_bx;
  logic [BW-1:0]     r_by;
  logic [BW-1:0]     r_bx_last;
  logic [BW-1:0]     r_by_last;
  logic              r_read;
  logic              r_busy;
  logic              r_done;
  logic [CW-1:0]     r_pending;
  logic              r_cu_valid;
  logic [23:0]       r_cu_data;

  logic [23:0]       w_fifo_dout;
  logic [CW-1:0]     w_fifo_count;
  logic              w_fifo_empty;
  logic              w_fifo_full;
  logic              w_accept;
  logic              w_last;
  logic              w_take;
  logic              w_bypass;
  logic              w_push;
  logic              w_pop;
  logic [CW:0]       w_inflight;
  logic              w_credit;
  logic [BW-1:0]     w_cfg_bx;
  logic [BW-1:0]     w_cfg_by;
  logic [ADDR_W-1:0] w_cfg_w;
  logic [ADDR_W-1:0] w_next_row;
  logic [ADDR_W-1:0] w_next_blk;
  logic [ADDR_W-1:0] w_next_brow;
  logic              w_unused;

  // Block counts come straight from the truncated dimensions
  assign w_cfg_bx = img_width[DIM_W-1:3];
  assign w_cfg_by = img_height[DIM_W-1:3];
  assign w_cfg_w  = ADDR_W'({w_cfg_bx, 3'b000});
  assign w_unused = &{1'b0, img_width[2:0], img_height[2:0], avm_readdata[31:24], w_fifo_full};

  assign w_accept = r_read & ~avm_waitrequest;
  assign w_last   = (r_c == LAST_IDX) & (r_r == LAST_IDX) &
                    (r_bx == r_bx_last) & (r_by == r_by_last);

  // Credit counts the read being accepted now but not pops, so returns can never overflow
  assign w_inflight = {1'b0, r_pending} + {1'b0, w_fifo_count} + {{CW{1'b0}}, w_accept};
  assign w_credit   = (w_inflight < (CW+1)'(FIFO_DEPTH));

  assign w_next_row  = r_row_addr + r_stride;
  assign w_next_blk  = r_blk_addr + BLK_STEP;
  assign w_next_brow = r_brow_addr + r_stride8;

  // A return arriving into an empty FIFO goes straight to the output register
  assign w_take   = (~w_fifo_empty | avm_readdatavalid) & ~R2Y_waitrequest;
  assign w_bypass = w_take & w_fifo_empty;
  assign w_pop    = w_take & ~w_fifo_empty;
  assign w_push   = avm_readdatavalid & ~w_bypass;

  ic_rgb_fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DW    (24)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (w_push),
    .pop     (w_pop),
    .din     (avm_readdata[23:0]),
    .dout    (w_fifo_dout),
    .count   (w_fifo_count),
    .empty   (w_fifo_empty),
    .full    (w_fifo_full)
  );

  // Reads accepted but not yet returned
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pending <= '0;
    end else begin
      case ({w_accept, avm_readdatavalid})
        2'b10:   r_pending <= r_pending + CW'(1);
        2'b01:   r_pending <= r_pending - CW'(1);
        default: r_pending <= r_pending;
      endcase
    end
  end

  // Registered pixel output; data holds while no pixel is issued
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cu_valid <= 1'b0;
      r_cu_data  <= '0;
    end else begin
      r_cu_valid <= w_take;
      if (w_take) begin
        r_cu_data <= w_bypass ? avm_readdata[23:0] : w_fifo_dout;
      end
    end
  end

  // Frame FSM with incremental block-order address generation
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_row_addr  <= '0;
      r_blk_addr  <= '0;
      r_brow_addr <= '0;
      r_stride    <= '0;
      r_stride8   <= '0;
      r_c         <= '0;
      r_r         <= '0;
      r_bx        <= '0;
      r_by        <= '0;
      r_bx_last   <= '0;
      r_by_last   <= '0;
      r_read      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_addr      <= base_addr;
            r_row_addr  <= base_addr;
            r_blk_addr  <= base_addr;
            r_brow_addr <= base_addr;
            r_stride    <= w_cfg_w << PIX_SH;
            r_stride8   <= w_cfg_w << (PIX_SH + BLK_SH);
            r_c         <= '0;
            r_r         <= '0;
            r_bx        <= '0;
            r_by        <= '0;
            r_bx_last   <= w_cfg_bx - BW'(1);
            r_by_last   <= w_cfg_by - BW'(1);
            if ((w_cfg_bx == '0) || (w_cfg_by == '0)) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_FETCH;
              r_busy  <= 1'b1;
              r_read  <= 1'b1;
            end
          end
        end
        ST_FETCH: begin
          if (w_accept) begin
            if (w_last) begin
              r_read  <= 1'b0;
              r_state <= ST_DRAIN;
            end else begin
              r_read <= w_credit;
              if (r_c != LAST_IDX) begin
                r_c    <= r_c + 3'd1;
                r_addr <= r_addr + PIX_STEP;
              end else if (r_r != LAST_IDX) begin
                r_c        <= '0;
                r_r        <= r_r + 3'd1;
                r_row_addr <= w_next_row;
                r_addr     <= w_next_row;
              end else if (r_bx != r_bx_last) begin
                r_c        <= '0;
                r_r        <= '0;
                r_bx       <= r_bx + BW'(1);
                r_blk_addr <= w_next_blk;
                r_row_addr <= w_next_blk;
                r_addr     <= w_next_blk;
              end else begin
                r_c         <= '0;
                r_r         <= '0;
                r_bx        <= '0;
                r_by        <= r_by + BW'(1);
                r_brow_addr <= w_next_brow;
                r_blk_addr  <= w_next_brow;
                r_row_addr  <= w_next_brow;
                r_addr      <= w_next_brow;
              end
            end
          end else if (!r_read) begin
            r_read <= w_credit;
          end
        end
        ST_DRAIN: begin
          if ((r_pending == '0) && w_fifo_empty) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign avm_address   = r_addr;
  assign avm_read      = r_read;
  assign CU_inputready = r_cu_valid;
  assign CU_readdata   = r_cu_data;
  assign busy          = r_busy;
  assign done          = r_done;

endmodule

// File: tb/tb_ic_rgb_block_fetch.sv
// tb/tb_ic_rgb_block_fetch.sv - directed bench for the block-order RGB fetcher
module tb_ic_rgb_block_fetch;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [15:0] img_width = '0;
  logic [15:0] img_height = '0;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] avm_readdata = '0;
  logic        avm_readdatavalid = 1'b0;
  logic        CU_inputready;
  logic [23:0] CU_readdata;
  logic        R2Y_waitrequest = 1'b0;
  logic        busy;
  logic        done;

  int checks = 0;
  int failures = 0;

  ic_rgb_block_fetch #(
    .ADDR_W     (32),
    .DIM_W      (16),
    .FIFO_DEPTH (8)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .start             (start),
    .base_addr         (base_addr),
    .img_width         (img_width),
    .img_height        (img_height),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .CU_inputready     (CU_inputready),
    .CU_readdata       (CU_readdata),
    .R2Y_waitrequest   (R2Y_waitrequest),
    .busy              (busy),
    .done              (done)
  );

  always #5 clk = ~clk;

  logic [23:0] got[$];
  logic [23:0] exp_q[$];
  bit          rand_wait = 1'b0;
  int          cyc = 0;
  int          acc_total = 0;
  int          read_cycles = 0;
  int          done_pulses = 0;
  int          stall_errs = 0;
  int          max_inflight = 0;
  int          first_rdv = -1;
  int          first_cu = -1;
  bit          acc_prev = 1'b0;
  bit          stall_prev = 1'b0;
  logic [31:0] addr_prev = '0;

  function automatic logic [23:0] pix(input logic [31:0] a);
    return a[25:2] ^ 24'h5A3C96;
  endfunction

  // Memory slave (1-cycle read latency, optional random stalls) and output monitor
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset_n) begin
        avm_readdatavalid = 1'b0;
        avm_waitrequest = 1'b0;
        acc_prev = 1'b0;
        stall_prev = 1'b0;
      end else begin
        avm_readdatavalid = acc_prev;
        avm_readdata = acc_prev ? {8'hC3, pix(addr_prev)} : 32'h0;
        if (acc_prev && first_rdv < 0) first_rdv = cyc;
        if (CU_inputready) begin
          got.push_back(CU_readdata);
          if (first_cu < 0) first_cu = cyc;
        end
        if (done) done_pulses++;
        if (acc_total - int'(got.size()) > max_inflight) max_inflight = acc_total - int'(got.size());
        if (stall_prev && (!avm_read || avm_address != addr_prev)) stall_errs++;
        avm_waitrequest = rand_wait ? 1'($urandom_range(0, 1)) : 1'b0;
        if (avm_read) read_cycles++;
        acc_prev = avm_read && !avm_waitrequest;
        stall_prev = avm_read && avm_waitrequest;
        addr_prev = avm_address;
        if (acc_prev) acc_total++;
      end
    end
  end

  task automatic clear_mon();
    got.delete();
    acc_total = 0;
    read_cycles = 0;
    done_pulses = 0;
    stall_errs = 0;
    max_inflight = 0;
    first_rdv = -1;
    first_cu = -1;
  endtask

  task automatic build_exp(input int w, input int h, input logic [31:0] base);
    exp_q.delete();
    for (int by = 0; by < h / 8; by++)
      for (int bx = 0; bx < w / 8; bx++)
        for (int r = 0; r < 8; r++)
          for (int c = 0; c < 8; c++)
            exp_q.push_back(pix(base + 32'(((by * 8 + r) * w + bx * 8 + c) * 4)));
  endtask

  function automatic int seq_errs();
    int n;
    n = (got.size() == exp_q.size()) ? 0 : 1;
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      if (got[i] !== exp_q[i]) n++;
    return n;
  endfunction

  task automatic pulse_start(input logic [31:0] b, input logic [15:0] w, input logic [15:0] h);
    @(negedge clk); #1;
    base_addr = b; img_width = w; img_height = h; start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk); #1;
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    checks++; if (avm_read !== 1'b0) begin failures++; $display("FAIL reset_read got=%b want=0", avm_read); end
    checks++; if (avm_address !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h want=0", avm_address); end
    checks++; if (CU_inputready !== 1'b0) begin failures++; $display("FAIL reset_cu_valid got=%b want=0", CU_inputready); end
    checks++; if (CU_readdata !== 24'h0) begin failures++; $display("FAIL reset_cu_data got=%h want=0", CU_readdata); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done); end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic_frame();
    bit ok;
    #1; clear_mon();
    build_exp(16, 8, 32'h1000);
    pulse_start(32'h1000, 16, 8);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b want=1", busy); end
    wait_done(2000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL basic_done_timeout got=0 want=1"); end
    checks++; if (got.size() != 128) begin failures++; $display("FAIL basic_count got=%0d want=128", got.size()); end
    checks++; if (seq_errs() != 0) begin failures++; $display("FAIL basic_seq mismatches=%0d want=0", seq_errs()); end
    checks++; if (got[8] !== pix(32'h1040)) begin failures++; $display("FAIL basic_pix9 got=%h want=%h", got[8], pix(32'h1040)); end
    checks++; if (got[64] !== pix(32'h1020)) begin failures++; $display("FAIL basic_pix65 got=%h want=%h", got[64], pix(32'h1020)); end
    checks++; if (first_cu - first_rdv != 1) begin failures++; $display("FAIL basic_latency got=%0d want=1", first_cu - first_rdv); end
    @(negedge clk); #1;
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL basic_done_width got=%b want=0", done); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_idle_busy got=%b want=0", busy); end
    checks++; if (done_pulses != 1) begin failures++; $display("FAIL basic_done_pulses got=%0d want=1", done_pulses); end
  endtask

  task automatic test_random_wait();
    bit ok;
    #1; clear_mon();
    rand_wait = 1'b1;
    build_exp(16, 8, 32'h1000);
    pulse_start(32'h1000, 16, 8);
    wait_done(4000, ok);
    rand_wait = 1'b0;
    checks++; if (!ok) begin failures++; $display("FAIL rwait_done_timeout got=0 want=1"); end
    checks++; if (seq_errs() != 0) begin failures++; $display("FAIL rwait_seq mismatches=%0d want=0", seq_errs()); end
    checks++; if (stall_errs != 0) begin failures++; $display("FAIL rwait_addr_stable violations=%0d want=0", stall_errs); end
    checks++; if (max_inflight > 8) begin failures++; $display("FAIL rwait_inflight got=%0d want<=8", max_inflight); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_r2y_hold();
    bit ok;
    int s0;
    int s1;
    #1; clear_mon();
    build_exp(16, 8, 32'h1000);
    pulse_start(32'h1000, 16, 8);
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk); #1;
      if (got.size() >= 20) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin failures++; $display("FAIL hold_reach20 got=%0d want>=20", got.size()); end
    R2Y_waitrequest = 1'b1;
    @(negedge clk); #1;
    s0 = got.size();
    repeat (39) @(negedge clk);
    #1;
    s1 = got.size();
    R2Y_waitrequest = 1'b0;
    checks++; if (s1 != s0) begin failures++; $display("FAIL hold_no_pulse got=%0d want=0 extra pulses", s1 - s0); end
    wait_done(2000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL hold_done_timeout got=0 want=1"); end
    checks++; if (seq_errs() != 0) begin failures++; $display("FAIL hold_seq mismatches=%0d want=0", seq_errs()); end
    checks++; if (max_inflight > 8) begin failures++; $display("FAIL hold_inflight got=%0d want<=8", max_inflight); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_zero_size();
    #1; clear_mon();
    pulse_start(32'h1000, 16'd20, 16'd7);
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL zero_done got=%b want=1", done); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL zero_busy got=%b want=0", busy); end
    @(negedge clk); #1;
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL zero_done_clear got=%b want=0", done); end
    repeat (5) @(negedge clk);
    #1;
    checks++; if (read_cycles != 0) begin failures++; $display("FAIL zero_reads got=%0d want=0", read_cycles); end
  endtask

  task automatic test_restart_ignored();
    bit ok;
    #1; clear_mon();
    build_exp(16, 8, 32'h1000);
    pulse_start(32'h1000, 16, 8);
    repeat (30) @(negedge clk);
    pulse_start(32'h8000, 16'd64, 16'd64);
    wait_done(2000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL restart_done_timeout got=0 want=1"); end
    checks++; if (seq_errs() != 0) begin failures++; $display("FAIL restart_seq mismatches=%0d want=0", seq_errs()); end
    repeat (20) @(negedge clk);
    #1;
    checks++; if (got.size() != 128) begin failures++; $display("FAIL restart_count got=%0d want=128", got.size()); end
    checks++; if (done_pulses != 1) begin failures++; $display("FAIL restart_done_pulses got=%0d want=1", done_pulses); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    #1; clear_mon();
    pulse_start(32'h2000, 16, 16);
    repeat (20) @(negedge clk);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    checks++; if (avm_read !== 1'b0) begin failures++; $display("FAIL rmid_read got=%b want=0", avm_read); end
    checks++; if (avm_address !== 32'h0) begin failures++; $display("FAIL rmid_addr got=%h want=0", avm_address); end
    checks++; if (CU_inputready !== 1'b0) begin failures++; $display("FAIL rmid_cu_valid got=%b want=0", CU_inputready); end
    checks++; if (CU_readdata !== 24'h0) begin failures++; $display("FAIL rmid_cu_data got=%h want=0", CU_readdata); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%b want=0", busy); end
    repeat (3) @(negedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk); #1;
    clear_mon();
    build_exp(8, 8, 32'h3000);
    pulse_start(32'h3000, 16'd8, 16'd8);
    wait_done(1000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rmid_done_timeout got=0 want=1"); end
    checks++; if (seq_errs() != 0) begin failures++; $display("FAIL rmid_seq mismatches=%0d want=0", seq_errs()); end
    checks++; if (got[0] !== pix(32'h3000)) begin failures++; $display("FAIL rmid_first got=%h want=%h", got[0], pix(32'h3000)); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_random_wait();
    test_r2y_hold();
    test_zero_size();
    test_restart_ignored();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
